// File: rtl/and_unit_arbiter_pkg.sv
// Shared definitions for the round-robin AND-unit arbiter: FSM state encoding
// and a constant-evaluable ceiling-log2 helper.
package and_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/and_unit_arbiter_vec_unit.sv
// Registered WIDTH-bit bitwise AND; the datapath shared by all requesters.
module and_vec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= a & b;
  end

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND unit among NUM_REQ requesters,
// returning result plus requester ID over a valid/ready handshake.
module and_unit_arbiter
  import and_unit_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = clog2_f(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] op_a,
  input  logic [NUM_REQ*WIDTH-1:0] op_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [WIDTH-1:0]         result,
  output logic [IDW-1:0]           result_id,
  output logic                     result_valid,
  input  logic                     result_ready
);

  state_t           state, state_nx;
  logic [IDW-1:0]   rr_ptr, win_id, pick_id;
  logic             pick_found;
  logic [NUM_REQ-1:0] req_rot;
  logic [WIDTH-1:0] a_lat, b_lat, pick_a, pick_b;
  int unsigned      sum_idx;

  // Rotating req by rr_ptr turns "first set bit from rr_ptr, wrapping" into a
  // plain lowest-index scan; the index is rotated back afterwards.
  always_comb begin
    req_rot    = NUM_REQ'({req, req} >> rr_ptr);
    pick_found = 1'b0;
    pick_id    = '0;
    sum_idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        sum_idx    = 32'(rr_ptr) + i;
        if (sum_idx >= NUM_REQ) sum_idx = sum_idx - NUM_REQ;
        pick_id    = IDW'(sum_idx);
      end
    end
  end

  always_comb begin
    pick_a = '0;
    pick_b = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (pick_id == IDW'(j)) begin
        pick_a = op_a[j*WIDTH +: WIDTH];
        pick_b = op_b[j*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (pick_found)   state_nx = ST_EXEC;
      ST_EXEC:                   state_nx = ST_RESP;
      ST_RESP: if (result_ready) state_nx = ST_IDLE;
      default:                   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != ST_IDLE);
    result_valid = (state == ST_RESP);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      gnt[k] = (state == ST_EXEC) && (win_id == IDW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      win_id <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
    end else begin
      if (state == ST_IDLE && pick_found) begin
        win_id <= pick_id;
        a_lat  <= pick_a;
        b_lat  <= pick_b;
      end
      if (state == ST_RESP && result_ready) begin
        rr_ptr <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
      end
    end
  end

  and_vec_unit #(.WIDTH(WIDTH)) u_and (
    .clk (clk),
    .rst (rst),
    .a   (a_lat),
    .b   (b_lat),
    .y   (result)
  );

  assign result_id = win_id;

endmodule
